// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button event block.
//   - btn_state_t       : FSM state encoding used by button_event
//   - DEF_LONG_CYCLES   : default long-press hold time (1 s at 50 MHz)
//   - DEF_REPEAT_CYCLES : default repeat interval (200 ms at 50 MHz)
//   - timer_width()     : width of the shared hold/repeat timer
// ---------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } btn_state_t;

    localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // The timer only ever has to reach (threshold - 1), so clog2 of the
    // larger threshold is enough bits. Never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned long_cycles,
                                                input int unsigned repeat_cycles);
        int unsigned span;
        span = max_u(long_cycles, repeat_cycles);
        return (span < 2) ? 1 : $clog2(span);
    endfunction

endpackage

// File: rtl/event_timer.sv
// ---------------------------------------------------------------------------
// event_timer
// Clearable up-counter with a terminal-count compare against a run-time
// limit. At the limit it either holds (saturate=1) or reloads to zero, so
// the count never goes past the limit.
//
// Ports
//   clock     in   system clock, rising edge
//   reset     in   asynchronous, active-high reset (count -> 0)
//   clear     in   synchronous clear, wins over enable
//   enable    in   count one step this clock
//   saturate  in   1: hold at limit, 0: reload to 0 at limit
//   limit     in   terminal count value
//   at_limit  out  count has reached the limit (combinational compare)
// ---------------------------------------------------------------------------
module event_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             saturate,
    input  logic [WIDTH-1:0] limit,
    output logic             at_limit
);

    logic [WIDTH-1:0] count;

    // >= rather than == so that a count left above a freshly lowered limit
    // is still treated as terminal instead of running off to wrap-around.
    assign at_limit = (count >= limit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (at_limit) begin
                if (!saturate) begin
                    count <= '0;
                end
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
// Turns a debounced button level into one-cycle event pulses: press,
// release, click (short press), long press and auto-repeat while held.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | button up, timer held at zero
//   ST_PRESSED | button down, counting towards the long-press threshold
//   ST_LONG    | long press reported, counting repeat intervals
//
// Parameters
//   LONG_CYCLES    clocks from the press pulse to the long_press pulse
//   REPEAT_CYCLES  clocks between repeat pulses after long_press
//   REPEAT_EN      1 = generate repeat pulses, 0 = none (timer saturates)
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   level          in   debounced level, 1 = pressed, synchronous to clock
//   press          out  one-cycle pulse when the button goes down
//   release_pulse  out  one-cycle pulse when the button goes up
//   click          out  one-cycle pulse on release before the long threshold
//   long_press     out  one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse   out  one-cycle pulse every REPEAT_CYCLES after long_press
//   held           out  1 while in ST_PRESSED or ST_LONG
//
// "release" and "repeat" are reserved words, hence the _pulse suffix on
// those two outputs.
//
// Latency: level is registered once (level_q) and every output is a
// register, so a level change sampled on edge N shows up on the outputs
// after edge N+1.
// ---------------------------------------------------------------------------
module button_event
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic press,
    output logic release_pulse,
    output logic click,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    generate
        if (LONG_CYCLES < 2) begin : g_bad_long
            $error("button_event: LONG_CYCLES must be >= 2");
        end
        if (REPEAT_CYCLES < 2) begin : g_bad_repeat
            $error("button_event: REPEAT_CYCLES must be >= 2");
        end
    endgenerate

    localparam int unsigned TIMER_W = timer_width(LONG_CYCLES, REPEAT_CYCLES);

    // Terminal counts are threshold-1: the timer is zeroed on the edge that
    // emits press (or long_press), so it sits at threshold-1 one clock before
    // the next event is due and the FSM registers the event on that edge.
    localparam logic [TIMER_W-1:0] LONG_LIMIT   = TIMER_W'(LONG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LIMIT = TIMER_W'(REPEAT_CYCLES - 1);
    localparam bit                 SATURATE     = !REPEAT_EN;

    btn_state_t         state;
    logic               level_q;
    logic               timer_tc;
    logic               timer_clear;
    logic               timer_enable;
    logic [TIMER_W-1:0] timer_limit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    // One timer serves both phases; the limit follows the state.
    assign timer_limit  = (state == ST_LONG) ? REPEAT_LIMIT : LONG_LIMIT;
    assign timer_enable = (state != ST_IDLE);

    // Zero in idle so the press edge starts from a clean count, zero again
    // on the PRESSED->LONG hand-over and on every repeat. With repeat off the
    // LONG-phase count is left to saturate at its limit instead.
    always_comb begin
        timer_clear = 1'b0;
        case (state)
            ST_PRESSED: timer_clear = timer_tc;
            ST_LONG:    timer_clear = timer_tc && REPEAT_EN;
            default:    timer_clear = 1'b1;
        endcase
    end

    event_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .saturate (SATURATE),
        .limit    (timer_limit),
        .at_limit (timer_tc)
    );

    // Release is tested before timer expiry in both held states, so a
    // release landing on the same clock as a long/repeat expiry suppresses
    // that event. Only one branch fires per clock, which also keeps press,
    // long_press and repeat_pulse mutually exclusive.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            click         <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            click         <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (level_q) begin
                        state <= ST_PRESSED;
                        press <= 1'b1;
                        held  <= 1'b1;
                    end
                end

                ST_PRESSED: begin
                    if (!level_q) begin
                        state         <= ST_IDLE;
                        release_pulse <= 1'b1;
                        click         <= 1'b1;
                        held          <= 1'b0;
                    end else if (timer_tc) begin
                        state      <= ST_LONG;
                        long_press <= 1'b1;
                    end
                end

                ST_LONG: begin
                    if (!level_q) begin
                        state         <= ST_IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (timer_tc && REPEAT_EN) begin
                        repeat_pulse <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
module tb_button_event;

    localparam int unsigned LC = 20;
    localparam int unsigned RC = 5;

    // event vector: {press, release, click, long_press, repeat}
    localparam logic [4:0] EV_PRESS = 5'b10000;
    localparam logic [4:0] EV_REL   = 5'b01000;
    localparam logic [4:0] EV_CLICK = 5'b00100;
    localparam logic [4:0] EV_LONG  = 5'b00010;
    localparam logic [4:0] EV_REP   = 5'b00001;

    typedef struct packed {
        int unsigned cyc;
        logic [4:0]  ev;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic level_a = 1'b0;
    logic level_b = 1'b0;

    logic press_a, rel_a, click_a, long_a, rep_a, held_a;
    logic press_b, rel_b, click_b, long_b, rep_b, held_b;
    logic [4:0] ev_a, ev_b;

    int unsigned cyc = 0;
    int n_tests = 0;
    int n_fail  = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign ev_a = {press_a, rel_a, click_a, long_a, rep_a};
    assign ev_b = {press_b, rel_b, click_b, long_b, rep_b};

    button_event #(.LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .REPEAT_EN(1'b1)) dut_a (
        .clock         (clock),
        .reset         (reset),
        .level         (level_a),
        .press         (press_a),
        .release_pulse (rel_a),
        .click         (click_a),
        .long_press    (long_a),
        .repeat_pulse  (rep_a),
        .held          (held_a)
    );

    button_event #(.LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .REPEAT_EN(1'b0)) dut_b (
        .clock         (clock),
        .reset         (reset),
        .level         (level_b),
        .press         (press_b),
        .release_pulse (rel_b),
        .click         (click_b),
        .long_press    (long_b),
        .repeat_pulse  (rep_b),
        .held          (held_b)
    );

    task automatic push_a(input int unsigned c, input logic [4:0] ev);
        exp_t e;
        e.cyc = c;
        e.ev  = ev;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int unsigned c, input logic [4:0] ev);
        exp_t e;
        e.cyc = c;
        e.ev  = ev;
        q_b.push_back(e);
    endtask

    task automatic check6(input string name, input logic [5:0] got, input logic [5:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: compares every output pulse against the scoreboard queue.
    task automatic mon(input int d, input logic [4:0] v);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (d == 0) begin
            while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
                e = q_a.pop_front();
                n_tests++; n_fail++;
                $display("FAIL missed_a: nothing seen at cycle %0d, required ev=%b", e.cyc, e.ev);
            end
        end else begin
            while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
                e = q_b.pop_front();
                n_tests++; n_fail++;
                $display("FAIL missed_b: nothing seen at cycle %0d, required ev=%b", e.cyc, e.ev);
            end
        end
        if (v != 5'b0) begin
            n_tests++;
            if ($countones({v[4], v[1], v[0]}) > 1) begin
                n_fail++;
                $display("FAIL onehot_%0d: got ev=%b at cycle %0d, required at most one of press/long/repeat", d, v, cyc);
            end
            if (d == 0 && q_a.size() > 0) begin
                e = q_a.pop_front(); have = 1'b1;
            end else if (d == 1 && q_b.size() > 0) begin
                e = q_b.pop_front(); have = 1'b1;
            end
            n_tests++;
            if (!have) begin
                n_fail++;
                $display("FAIL event_%0d: got ev=%b at cycle %0d, required no event", d, v, cyc);
            end else if (e.cyc != cyc || e.ev != v) begin
                n_fail++;
                $display("FAIL event_%0d: got ev=%b at cycle %0d, required ev=%b at cycle %0d",
                         d, v, cyc, e.ev, e.cyc);
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            mon(0, ev_a);
            mon(1, ev_b);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        int unsigned c2;

        #1;
        check6("reset_outs_a", {ev_a, held_a}, 6'b0);
        check6("reset_outs_b", {ev_b, held_b}, 6'b0);
        wait_neg(3);
        reset = 1'b0;
        wait_neg(3);

        // short press, 8 clocks
        c = cyc;
        level_a = 1'b1;
        push_a(c + 2, EV_PRESS);
        push_a(c + 10, EV_REL | EV_CLICK);
        wait_neg(4);
        check6("held_short", {5'b0, held_a}, 6'b000001);
        wait_neg(4);
        level_a = 1'b0;
        wait_neg(6);
        check6("idle_after_short", {5'b0, held_a}, 6'b0);

        // 40-clock hold: long press, three repeats, release wins over 4th repeat
        c = cyc;
        level_a = 1'b1;
        push_a(c + 2,  EV_PRESS);
        push_a(c + 22, EV_LONG);
        push_a(c + 27, EV_REP);
        push_a(c + 32, EV_REP);
        push_a(c + 37, EV_REP);
        push_a(c + 42, EV_REL);
        wait_neg(40);
        level_a = 1'b0;
        wait_neg(8);

        // release lands on the long-press edge: click, no long_press
        c = cyc;
        level_a = 1'b1;
        push_a(c + 2,  EV_PRESS);
        push_a(c + 22, EV_REL | EV_CLICK);
        wait_neg(20);
        level_a = 1'b0;
        wait_neg(6);

        // one clock longer: long_press, then release without click
        c = cyc;
        level_a = 1'b1;
        push_a(c + 2,  EV_PRESS);
        push_a(c + 22, EV_LONG);
        push_a(c + 23, EV_REL);
        wait_neg(21);
        level_a = 1'b0;
        wait_neg(6);

        // repeat disabled, 60-clock hold
        c = cyc;
        level_b = 1'b1;
        push_b(c + 2,  EV_PRESS);
        push_b(c + 22, EV_LONG);
        push_b(c + 62, EV_REL);
        wait_neg(50);
        check6("held_norepeat", {5'b0, held_b}, 6'b000001);
        wait_neg(10);
        level_b = 1'b0;
        wait_neg(6);

        // reset 10 clocks into a hold, level stays high
        c = cyc;
        level_a = 1'b1;
        push_a(c + 2, EV_PRESS);
        wait_neg(10);
        check6("held_before_reset", {ev_a, held_a}, 6'b000001);
        #1 reset = 1'b1;
        #1;
        check6("async_reset_a", {ev_a, held_a}, 6'b0);
        check6("async_reset_b", {ev_b, held_b}, 6'b0);
        wait_neg(2);
        reset = 1'b0;
        c2 = cyc;
        push_a(c2 + 2,  EV_PRESS);
        push_a(c2 + 22, EV_LONG);
        push_a(c2 + 27, EV_REL);
        wait_neg(25);
        level_a = 1'b0;
        wait_neg(8);

        // single-clock level pulse on both instances
        c = cyc;
        level_a = 1'b1;
        level_b = 1'b1;
        push_a(c + 2, EV_PRESS);
        push_a(c + 3, EV_REL | EV_CLICK);
        push_b(c + 2, EV_PRESS);
        push_b(c + 3, EV_REL | EV_CLICK);
        wait_neg(1);
        level_a = 1'b0;
        level_b = 1'b0;
        wait_neg(6);

        n_tests++;
        if (q_a.size() != 0) begin
            n_fail++;
            $display("FAIL pending_a: got %0d unseen events, required 0", q_a.size());
        end
        n_tests++;
        if (q_b.size() != 0) begin
            n_fail++;
            $display("FAIL pending_b: got %0d unseen events, required 0", q_b.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter LONG_CYCLES, default 50_000_000, hold time in clocks from press pulse to long_press pulse (1 s at 50 MHz).
REQ-002 Parameter REPEAT_CYCLES, default 10_000_000, clocks between successive repeat pulses (200 ms at 50 MHz).
REQ-003 Parameter REPEAT_EN, default 1, 1 enables repeat generation, 0 suppresses it.
REQ-004 clock  input  1  single system clock, 50 MHz, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 level  input  1  debounced button level from debouncer, 1 = pressed, synchronous to clock.
REQ-007 press  output  1  one-cycle pulse on press.
REQ-008 release  output  1  one-cycle pulse on release.
REQ-009 click  output  1  one-cycle pulse on release before long threshold.
REQ-010 long_press  output  1  one-cycle pulse when hold reaches LONG_CYCLES.
REQ-011 repeat  output  1  one-cycle pulse every REPEAT_CYCLES while held after long_press.
REQ-012 held  output  1  registered level, 1 while in PRESSED or LONG.

Function
REQ-013 level SHALL be registered once (level_q); all decisions use level_q.
REQ-014 All outputs SHALL be registered; the first edge sampling level=1 is edge N; press SHALL be high from edge N+1 to N+2 (2-edge latency), same latency for release.
REQ-015 FSM states: IDLE, PRESSED, LONG.
REQ-016 IDLE: level_q=1 -> PRESSED, assert press, clear timer.
REQ-017 PRESSED: timer increments each clock; level_q=0 -> IDLE, assert release and click in the same cycle.
REQ-018 PRESSED: timer reaching LONG_CYCLES-1 with level_q=1 -> LONG, assert long_press exactly LONG_CYCLES clocks after press, clear timer.
REQ-019 LONG: timer increments; on reaching REPEAT_CYCLES-1 with REPEAT_EN=1, assert repeat and clear timer; with REPEAT_EN=0 timer SHALL saturate, no repeat.
REQ-020 LONG: level_q=0 -> IDLE, assert release only (no click).
REQ-021 Simultaneous release and timer expiry SHALL resolve release-wins: no long_press/repeat that cycle; in PRESSED click is asserted.
REQ-022 At most one of press, long_press, repeat SHALL be high in any cycle; release and click may coincide.
REQ-023 Timer width SHALL be clog2(max(LONG_CYCLES, REPEAT_CYCLES)); no wrap-around, counter never exceeds its threshold.
REQ-024 LONG_CYCLES and REPEAT_CYCLES SHALL be >= 2; elaboration-time error otherwise.
REQ-025 Level pulse of 1 clock SHALL still produce exactly one press and one release (and click).

Reset
REQ-026 reset asserted SHALL force state IDLE, timer 0, level_q 0, all outputs 0 immediately, independent of clock.
REQ-027 Reset mid-press SHALL emit no release/click; after deassertion with level still 1, a fresh press SHALL be generated at latency of REQ-014.
REQ-028 Reset deassertion is assumed synchronised externally to clock.

Structure
REQ-029 State encoding and default timing constants (LONG_CYCLES, REPEAT_CYCLES at 50 MHz) SHALL live in shared package button_pkg.
REQ-030 One sub-module, event_timer (clearable up-counter with terminal-count compare and saturate option), SHALL be used for the timer.

Verification (bench: LONG_CYCLES=20, REPEAT_CYCLES=5)
REQ-031 level high 8 clocks then low -> press at N+1, release and click together 8 clocks later, no long_press.
REQ-032 level high 40 clocks -> press, long_press 20 clocks after press, repeat at +5, +10, +15, then release only, no click.
REQ-033 level falls on exact cycle long_press would fire -> release and click, no long_press.
REQ-034 REPEAT_EN=0, level high 60 clocks -> single long_press, zero repeat pulses, release at end.
REQ-035 reset asserted 10 clocks into hold, level remains 1 -> outputs 0 asynchronously, no release; after deassertion new press, long_press 20 clocks later.
REQ-036 level high for 1 clock -> exactly one press, one release, one click; one-hot check on press/long_press/repeat throughout all tests.
